// File: rtl/rob_buffer_if.sv
// Reorder-buffer bus: allocation handshake, CDB write-back, operand lookup and
// the retirement stream toward the register file.
//   master : decoder / CDB / RS side (drives alloc_*, wb_*, query_entry)
//   slave  : the ROB (drives alloc_ready/entry, query_ready/value, commit_*)
interface rob_buffer_if #(
  parameter int unsigned ENTRY_W = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5
);
  logic               alloc_valid;
  logic [REG_W-1:0]   alloc_dest;
  logic               alloc_ready;
  logic [ENTRY_W-1:0] alloc_entry;

  logic               wb_valid;
  logic [ENTRY_W-1:0] wb_entry;
  logic [DATA_W-1:0]  wb_value;

  logic [ENTRY_W-1:0] query_entry;
  logic               query_ready;
  logic [DATA_W-1:0]  query_value;

  logic               commit_valid;
  logic [ENTRY_W-1:0] commit_entry;
  logic [REG_W-1:0]   commit_reg;
  logic [DATA_W-1:0]  commit_value;

  modport master (
    output alloc_valid, alloc_dest, wb_valid, wb_entry, wb_value, query_entry,
    input  alloc_ready, alloc_entry, query_ready, query_value,
    input  commit_valid, commit_entry, commit_reg, commit_value
  );

  modport slave (
    input  alloc_valid, alloc_dest, wb_valid, wb_entry, wb_value, query_entry,
    output alloc_ready, alloc_entry, query_ready, query_value,
    output commit_valid, commit_entry, commit_reg, commit_value
  );
endinterface

// File: rtl/rob_buffer.sv
// Reorder buffer downstream of the CDB. Entries are allocated in program
// order at tail, completed out of order by CDB write-backs, and retired
// in order from head at most one per cycle.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-low reset (clears values too)
//   flush : synchronous discard of all in-flight entries, beats alloc/wb/commit
//   bus   : rob_buffer_if slave (alloc, write-back, query, commit)
module rob_buffer #(
  parameter int unsigned ENTRY_W = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  rob_buffer_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << ENTRY_W;
  localparam logic [ENTRY_W:0] CountFull = (ENTRY_W + 1)'(DEPTH);

  logic [DEPTH-1:0]   busy_q;
  logic [DEPTH-1:0]   done_q;
  logic [REG_W-1:0]   dest_q  [DEPTH];
  logic [DATA_W-1:0]  value_q [DEPTH];
  logic [ENTRY_W-1:0] head_q;
  logic [ENTRY_W-1:0] tail_q;
  logic [ENTRY_W:0]   count_q;

  logic               commit_valid_q;
  logic [ENTRY_W-1:0] commit_entry_q;
  logic [REG_W-1:0]   commit_reg_q;
  logic [DATA_W-1:0]  commit_value_q;

  logic alloc_ok;
  logic do_alloc;
  logic do_commit;
  logic wb_hit;

  always_comb begin
    // Space is judged on registered count only; a retire this cycle frees nothing yet.
    alloc_ok  = (count_q != CountFull);
    do_alloc  = bus.alloc_valid && alloc_ok;
    // Commit looks at pre-edge done, so a write-back to head retires one edge later.
    do_commit = (count_q != '0) && busy_q[head_q] && done_q[head_q];
    wb_hit    = bus.wb_valid && busy_q[bus.wb_entry];
  end

  assign bus.alloc_ready  = alloc_ok;
  assign bus.alloc_entry  = tail_q;
  assign bus.query_ready  = busy_q[bus.query_entry] && done_q[bus.query_entry];
  assign bus.query_value  = value_q[bus.query_entry];
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_entry = commit_entry_q;
  assign bus.commit_reg   = commit_reg_q;
  assign bus.commit_value = commit_value_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      done_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_entry_q <= '0;
      commit_reg_q   <= '0;
      commit_value_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i]  <= '0;
        value_q[i] <= '0;
      end
    end else if (flush) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      done_q         <= '0;
      commit_valid_q <= 1'b0;
    end else begin
      if (wb_hit) begin
        done_q[bus.wb_entry]  <= 1'b1;
        value_q[bus.wb_entry] <= bus.wb_value;
      end
      // Placed after the write-back so retiring head wins over a same-edge wb to it.
      if (do_commit) begin
        commit_valid_q  <= 1'b1;
        commit_entry_q  <= head_q;
        commit_reg_q    <= dest_q[head_q];
        commit_value_q  <= value_q[head_q];
        busy_q[head_q]  <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + 1'b1;
      end else begin
        commit_valid_q <= 1'b0;
      end
      // tail never equals a busy head here since alloc requires not full.
      if (do_alloc) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        dest_q[tail_q] <= bus.alloc_dest;
        tail_q         <= tail_q + 1'b1;
      end
      unique case ({do_alloc, do_commit})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
